// File: rtl/sm3_res_serializer_if.sv
// sm3_res_serializer_if: digest capture input and beat-stream output bundle
interface sm3_res_serializer_if #(parameter int OUT_DW = 32);
  logic cmprss_otpt_vld;
  logic [255:0] cmprss_otpt_res;
  logic res_otpt_vld;
  logic res_otpt_rdy;
  logic [OUT_DW-1:0] res_otpt_d;
  logic res_otpt_lst;
  logic [2:0] res_otpt_idx;
  logic [2:0] buf_cnt;
  logic ovf;
  logic ovf_clr;
  modport master (
    output cmprss_otpt_vld, cmprss_otpt_res, res_otpt_rdy, ovf_clr,
    input res_otpt_vld, res_otpt_d, res_otpt_lst, res_otpt_idx, buf_cnt, ovf
  );
  modport slave (
    input cmprss_otpt_vld, cmprss_otpt_res, res_otpt_rdy, ovf_clr,
    output res_otpt_vld, res_otpt_d, res_otpt_lst, res_otpt_idx, buf_cnt, ovf
  );
endinterface

// File: rtl/sm3_res_serializer.sv
// sm3_res_serializer: buffers 256-bit digests and streams them MSW-first as OUT_DW-bit beats
module sm3_res_serializer #(
  parameter int OUT_DW = 32,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  sm3_res_serializer_if.slave bus
);
  localparam int BPD = 256 / OUT_DW;
  localparam int IW = $clog2(BPD);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [BPD-1:0][OUT_DW-1:0] slot [DEPTH];
  logic [PW-1:0] wp, rp, wp_n, rp_n;
  logic [2:0] cnt, cnt_n, idx, idx_n;
  logic [IW-1:0] sel;
  logic vld, lst, ovf, xfer, pop, push, drop;
  assign vld = state == SEND;
  assign sel = IW'(BPD - 1) - idx[IW-1:0];
  assign bus.res_otpt_vld = vld;
  assign bus.res_otpt_d = vld ? slot[rp][sel] : '0;
  assign bus.res_otpt_lst = lst;
  assign bus.res_otpt_idx = idx;
  assign bus.buf_cnt = cnt;
  assign bus.ovf = ovf;
  // A full buffer still accepts a digest when the head's last beat leaves in the same cycle
  always_comb begin
    xfer = vld & bus.res_otpt_rdy;
    pop = xfer & lst;
    push = bus.cmprss_otpt_vld & ((cnt < 3'(DEPTH)) | pop);
    drop = bus.cmprss_otpt_vld & ~push;
    cnt_n = cnt + 3'(push) - 3'(pop);
    idx_n = pop ? 3'd0 : xfer ? idx + 3'd1 : idx;
    rp_n = pop ? (rp == LAST_P ? '0 : rp + PW'(1)) : rp;
    wp_n = push ? (wp == LAST_P ? '0 : wp + PW'(1)) : wp;
  end
  // Digest storage needs no reset: an empty buffer is never read
  always_ff @(posedge clk)
    if (push) slot[wp] <= bus.cmprss_otpt_res;
  // Output FSM, pointers, occupancy and sticky overflow; next beat is valid whenever a digest remains
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      idx <= '0;
      lst <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= cnt_n != 3'd0 ? SEND : IDLE;
      wp <= wp_n;
      rp <= rp_n;
      cnt <= cnt_n;
      idx <= idx_n;
      lst <= idx_n == 3'(BPD - 1);
      ovf <= drop ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf;
    end
  end
endmodule

// File: tb/tb_sm3_res_serializer.sv
// tb_sm3_res_serializer: directed checks of capture, streaming, backpressure, overflow and reset
module tb_sm3_res_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  localparam logic [255:0] DG = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [31:0] W [8] = '{32'h66c7f0f4, 32'h62eeedd9, 32'hd1f2d46b, 32'hdc10e4e2,
                                    32'h4167c487, 32'h5cf2f7a2, 32'h297da02b, 32'h8f4ba8e0};
  localparam logic [255:0] DA = 256'ha0000000_a0000001_a0000002_a0000003_a0000004_a0000005_a0000006_a0000007;
  localparam logic [255:0] DB = 256'hb0000000_b0000001_b0000002_b0000003_b0000004_b0000005_b0000006_b0000007;

  sm3_res_serializer_if #(.OUT_DW(32)) b32 ();
  sm3_res_serializer_if #(.OUT_DW(64)) b64 ();
  sm3_res_serializer #(.OUT_DW(32), .DEPTH(2)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
  sm3_res_serializer #(.OUT_DW(64), .DEPTH(2)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [255:0] v);
    b32.cmprss_otpt_vld = 1'b1;
    b32.cmprss_otpt_res = v;
    tick();
    b32.cmprss_otpt_vld = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input int i, input logic l);
    chk({tag, "_vld"}, 64'(b32.res_otpt_vld), 64'd1);
    chk({tag, "_d"}, 64'(b32.res_otpt_d), 64'(d));
    chk({tag, "_idx"}, 64'(b32.res_otpt_idx), 64'(i));
    chk({tag, "_lst"}, 64'(b32.res_otpt_lst), 64'(l));
  endtask

  initial begin
    b32.cmprss_otpt_vld = 1'b0; b32.cmprss_otpt_res = '0; b32.res_otpt_rdy = 1'b0; b32.ovf_clr = 1'b0;
    b64.cmprss_otpt_vld = 1'b0; b64.cmprss_otpt_res = '0; b64.res_otpt_rdy = 1'b0; b64.ovf_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_vld", 64'(b32.res_otpt_vld), 64'd0);
    chk("rst_d", 64'(b32.res_otpt_d), 64'd0);
    chk("rst_lst", 64'(b32.res_otpt_lst), 64'd0);
    chk("rst_idx", 64'(b32.res_otpt_idx), 64'd0);
    chk("rst_cnt", 64'(b32.buf_cnt), 64'd0);
    chk("rst_ovf", 64'(b32.ovf), 64'd0);
    chk("rst_vld64", 64'(b64.res_otpt_vld), 64'd0);

    // single digest, rdy held high
    b32.res_otpt_rdy = 1'b1;
    chk("t1_pre_vld", 64'(b32.res_otpt_vld), 64'd0);
    strobe(DG);
    chk("t1_cnt1", 64'(b32.buf_cnt), 64'd1);
    for (int i = 0; i < 8; i++) begin
      beat("t1", W[i], i, i == 7);
      tick();
    end
    chk("t1_end_vld", 64'(b32.res_otpt_vld), 64'd0);
    chk("t1_end_cnt", 64'(b32.buf_cnt), 64'd0);

    // 64-bit beats with rdy toggling
    b64.cmprss_otpt_vld = 1'b1;
    b64.cmprss_otpt_res = DG;
    tick();
    b64.cmprss_otpt_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_vld", 64'(b64.res_otpt_vld), 64'd1);
      chk("t2_d", b64.res_otpt_d, {W[2*i], W[2*i+1]});
      chk("t2_idx", 64'(b64.res_otpt_idx), 64'(i));
      chk("t2_lst", 64'(b64.res_otpt_lst), 64'(i == 3));
      b64.res_otpt_rdy = 1'b0;
      tick();
      chk("t2_hold_vld", 64'(b64.res_otpt_vld), 64'd1);
      chk("t2_hold_d", b64.res_otpt_d, {W[2*i], W[2*i+1]});
      chk("t2_hold_idx", 64'(b64.res_otpt_idx), 64'(i));
      b64.res_otpt_rdy = 1'b1;
      tick();
    end
    b64.res_otpt_rdy = 1'b0;
    chk("t2_end_vld", 64'(b64.res_otpt_vld), 64'd0);

    // overflow: three strobes into a two-entry buffer
    b32.res_otpt_rdy = 1'b0;
    strobe(DA);
    strobe(DB);
    chk("t3_ovf_pre", 64'(b32.ovf), 64'd0);
    strobe(DG);
    chk("t3_cnt", 64'(b32.buf_cnt), 64'd2);
    chk("t3_ovf", 64'(b32.ovf), 64'd1);
    b32.res_otpt_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat("t3", i < 8 ? DA[255-32*i -: 32] : DB[255-32*(i-8) -: 32], i % 8, (i % 8) == 7);
      tick();
    end
    chk("t3_end_vld", 64'(b32.res_otpt_vld), 64'd0);
    chk("t3_end_cnt", 64'(b32.buf_cnt), 64'd0);
    b32.ovf_clr = 1'b1;
    tick();
    b32.ovf_clr = 1'b0;
    chk("t3_clr", 64'(b32.ovf), 64'd0);

    // full buffer, capture coincides with head's last-beat handshake
    b32.res_otpt_rdy = 1'b0;
    strobe(DA);
    strobe(DB);
    b32.res_otpt_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat("t4a", DA[255-32*i -: 32], i, i == 7);
      if (i == 7) begin
        b32.cmprss_otpt_vld = 1'b1;
        b32.cmprss_otpt_res = DG;
      end
      tick();
    end
    b32.cmprss_otpt_vld = 1'b0;
    chk("t4_ovf", 64'(b32.ovf), 64'd0);
    chk("t4_cnt", 64'(b32.buf_cnt), 64'd2);
    for (int i = 0; i < 8; i++) begin
      beat("t4b", DB[255-32*i -: 32], i, i == 7);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      beat("t4c", W[i], i, i == 7);
      tick();
    end
    chk("t4_end_vld", 64'(b32.res_otpt_vld), 64'd0);

    // set beats clear in the same cycle
    b32.res_otpt_rdy = 1'b0;
    strobe(DA);
    strobe(DB);
    strobe(DG);
    chk("t5_ovf_set", 64'(b32.ovf), 64'd1);
    b32.ovf_clr = 1'b1;
    strobe(DG);
    chk("t5_set_wins", 64'(b32.ovf), 64'd1);
    tick();
    b32.ovf_clr = 1'b0;
    chk("t5_clr", 64'(b32.ovf), 64'd0);
    chk("t5_cnt", 64'(b32.buf_cnt), 64'd2);

    // reset mid-digest with another queued
    b32.res_otpt_rdy = 1'b1;
    tick();
    tick();
    tick();
    beat("t6_pre", DA[255-96 -: 32], 3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_vld", 64'(b32.res_otpt_vld), 64'd0);
    chk("t6_cnt", 64'(b32.buf_cnt), 64'd0);
    chk("t6_idx", 64'(b32.res_otpt_idx), 64'd0);
    chk("t6_d", 64'(b32.res_otpt_d), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_quiet", 64'(b32.res_otpt_vld), 64'd0);
    end
    strobe(DG);
    beat("t6_new", W[0], 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
